jt51_lfo_pm: RTL

Pitch-modulation LFO stage feeding `jt51_pm`. Once per 32-slot sample frame it advances a low-frequency oscillator at the LFRQ-selected rate. It shapes the oscillator into one of four waveforms and scales the result by PMD. It delivers the 9-bit magnitude `pm_mod` and direction `pm_add` that `jt51_pm` adds to or subtracts from KC/KF.

---
 rtl/jt51_lfo_pkg.sv | 23 ++
 rtl/jt51_lfo_wave.sv | 35 +++
 rtl/jt51_lfo_pm.sv | 81 ++++++++
 3 files changed

// File: rtl/jt51_lfo_pkg.sv
// Shared constants for the YM2151 pitch-modulation LFO: waveform codes, LFSR shape, widths.
package jt51_lfo_pkg;

    typedef enum logic [1:0] {
        LFO_SAW   = 2'd0,
        LFO_SQR   = 2'd1,
        LFO_TRI   = 2'd2,
        LFO_NOISE = 2'd3
    } lfo_wave_e;

    localparam int unsigned PRE_W  = 20;
    localparam int unsigned PM_W   = 9;
    localparam int unsigned LFSR_W = 17;

    localparam logic [LFSR_W-1:0] LFSR_SEED   = 17'h1FFFF;
    localparam int unsigned       LFSR_TAP_HI = 16;
    localparam int unsigned       LFSR_TAP_LO = 13;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/jt51_lfo_wave.sv
// Combinational LFO waveform shaper: phase or noise bits to sign plus 7-bit magnitude.
module jt51_lfo_wave
    import jt51_lfo_pkg::*;
(
    input  logic [1:0] lfo_w_i,
    input  logic [7:0] p_i,
    input  logic [7:0] lfsr_i,
    output logic       s_o,
    output logic [6:0] m_o
);

    always_comb begin
        s_o = 1'b0;
        m_o = '0;
        unique case (lfo_wave_e'(lfo_w_i))
            LFO_SAW: begin
                s_o = ~p_i[7];
                m_o = p_i[7] ? p_i[6:0] : ~p_i[6:0];
            end
            LFO_SQR: begin
                s_o = p_i[7];
                m_o = 7'd127;
            end
            LFO_TRI: begin
                s_o = p_i[7];
                m_o = p_i[6] ? {~p_i[5:0], 1'b1} : {p_i[5:0], 1'b0};
            end
            LFO_NOISE: begin
                s_o = lfsr_i[0];
                m_o = lfsr_i[7:1];
            end
        endcase
    end

endmodule

// File: rtl/jt51_lfo_pm.sv
// Pitch-modulation LFO: frame-rate prescaler, phase and noise LFSR, depth-scaled output register.
module jt51_lfo_pm
    import jt51_lfo_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            zero,
    input  logic            lfo_rst,
    input  logic [7:0]      lfo_freq,
    input  logic [1:0]      lfo_w,
    input  logic [6:0]      lfo_pmd,
    output logic [PM_W-1:0] pm_mod,
    output logic            pm_add,
    output logic [7:0]      lfo_phase
);

    logic [PRE_W-1:0]  pre_q, pre_d, inc;
    logic [PRE_W:0]    sum;
    logic [7:0]        phase_q, phase_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [PM_W-1:0]   mod_q, mod_d;
    logic              add_q, add_d;
    logic              wave_s;
    logic [6:0]        wave_m;
    logic [13:0]       prod;

    jt51_lfo_wave u_wave (
        .lfo_w_i (lfo_w),
        .p_i     (phase_q),
        .lfsr_i  (lfsr_q[7:0]),
        .s_o     (wave_s),
        .m_o     (wave_m)
    );

    // Overflow of the 20-bit accumulator is the phase tick; at most one per frame.
    always_comb begin
        inc     = PRE_W'({1'b1, lfo_freq[3:0]}) << lfo_freq[7:4];
        sum     = {1'b0, pre_q} + {1'b0, inc};
        pre_d   = pre_q;
        phase_d = phase_q;
        lfsr_d  = lfsr_q;
        if (lfo_rst) begin
            pre_d   = '0;
            phase_d = '0;
        end else if (zero) begin
            pre_d = sum[PRE_W-1:0];
            if (sum[PRE_W]) begin
                phase_d = phase_q + 8'd1;
                lfsr_d  = lfsr_step(lfsr_q);
            end
        end
    end

    always_comb begin
        prod  = {7'd0, wave_m} * {7'd0, lfo_pmd};
        mod_d = PM_W'(prod >> 5);
        add_d = (mod_d == '0) ? 1'b1 : ~wave_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= '0;
            lfsr_q  <= LFSR_SEED;
            mod_q   <= '0;
            add_q   <= 1'b1;
        end else if (cen) begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
            mod_q   <= mod_d;
            add_q   <= add_d;
        end
    end

    assign pm_mod    = mod_q;
    assign pm_add    = add_q;
    assign lfo_phase = phase_q;

endmodule
